// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : state type and sizing helpers shared by uart_tx and uart_rx
// Revision : 1.0
// ============================================================================
package uart_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } uart_state_e;

   // Start bit + data bits + stop bit.
   function automatic int FRAME_BITS(input int bits_per_word);
      return bits_per_word + 2;
   endfunction

   function automatic int cnt_width(input int count_range);
      return (count_range > 1) ? $clog2(count_range) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_pulse_counter.sv
`default_nettype none
// ============================================================================
// uart_pulse_counter : emits one tick per UART bit period while enabled
// Revision : 1.0
// ============================================================================
module uart_pulse_counter
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_PULSE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam int               CNT_W = cnt_width(CLOCKS_PER_PULSE);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLOCKS_PER_PULSE - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Equality against LAST keeps CLOCKS_PER_PULSE=1 ticking every cycle.
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (en) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx : serialises one W_in-bit word as back-to-back 8N1 characters
// Revision : 1.0
// ============================================================================
module uart_tx
   import uart_pkg::*;
#(
   parameter int  CLOCKS_PER_PULSE = 4,
   parameter int  BITS_PER_WORD    = 8,
   parameter int  W_in             = 16,
   localparam int NUM_WORDS        = W_in / BITS_PER_WORD
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    s_valid,
   output logic                                    s_ready,
   input  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] s_data,
   output logic                                    tx,
   output logic                                    busy
);

   localparam int                NBITS     = FRAME_BITS(BITS_PER_WORD);
   localparam int                BIT_W     = cnt_width(NBITS);
   localparam int                WORD_W    = cnt_width(NUM_WORDS);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(NBITS - 1);
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_WORDS - 1);

   generate
      if (W_in % BITS_PER_WORD != 0) begin : g_bad_width
         $error("uart_tx: W_in must be a multiple of BITS_PER_WORD");
      end
      if (CLOCKS_PER_PULSE < 1) begin : g_bad_pulse
         $error("uart_tx: CLOCKS_PER_PULSE must be at least 1");
      end
   endgenerate

   uart_state_e                            state_q, state_d;
   logic [BIT_W-1:0]                       bit_idx_q, bit_idx_d;
   logic [WORD_W-1:0]                      word_idx_q, word_idx_d;
   logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] data_q, data_d;
   logic                                   tx_q, tx_d;
   logic                                   busy_q, busy_d;
   logic                                   s_ready_q, s_ready_d;

   logic             handshake;
   logic             pulse_tick;
   logic [NBITS-1:0] frame;
   logic [BIT_W-1:0] next_bit;

   assign handshake = (state_q == IDLE) && s_ready_q && s_valid;
   assign frame     = {1'b1, data_q[word_idx_q], 1'b0};
   assign next_bit  = bit_idx_q + 1'b1;

   uart_pulse_counter #(
      .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
   ) u_pulse (
      .clk  (clk),
      .rst  (rst),
      .clear(handshake),
      .en   (state_q == SEND),
      .tick (pulse_tick)
   );

   // tx is registered from the next bit index, so the start bit appears
   // on the cycle right after the handshake edge.
   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      word_idx_d = word_idx_q;
      data_d     = data_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      s_ready_d  = s_ready_q;
      case (state_q)
         IDLE: begin
            s_ready_d = 1'b1;
            tx_d      = 1'b1;
            busy_d    = 1'b0;
            if (handshake) begin
               data_d     = s_data;
               bit_idx_d  = '0;
               word_idx_d = '0;
               tx_d       = 1'b0;
               busy_d     = 1'b1;
               s_ready_d  = 1'b0;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (pulse_tick) begin
               if (bit_idx_q != LAST_BIT) begin
                  bit_idx_d = next_bit;
                  tx_d      = frame[next_bit];
               end else if (word_idx_q != LAST_WORD) begin
                  bit_idx_d  = '0;
                  word_idx_d = word_idx_q + 1'b1;
                  tx_d       = 1'b0;
               end else begin
                  bit_idx_d  = '0;
                  word_idx_d = '0;
                  tx_d       = 1'b1;
                  busy_d     = 1'b0;
                  s_ready_d  = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         bit_idx_q  <= '0;
         word_idx_q <= '0;
         data_q     <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         s_ready_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_idx_q  <= bit_idx_d;
         word_idx_q <= word_idx_d;
         data_q     <= data_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         s_ready_q  <= s_ready_d;
      end
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign s_ready = s_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_uart_tx : two uart_tx instances (4 and 1 clocks per bit) against a frame model
// Revision : 1.0
// ============================================================================
module tb_uart_tx;

   logic        clk;
   logic        rst     [2];
   logic        s_valid [2];
   logic        s_ready [2];
   logic [15:0] s_data  [2];
   logic        tx      [2];
   logic        busy    [2];

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int n_rx    [2] = '{0, 0};
   int n_req   [2] = '{0, 0};
   int n_abort [2] = '{0, 0};

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int inst, input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d] @cycle %0d: got %0h, expected %0h", name, inst, cyc, act, exp);
   endtask

   // Line level of frame position k (cycles since the handshake edge, minus one).
   function automatic logic fbit(input logic [15:0] w, input int k, input int cpp);
      int p, ch, b;
      p  = k / cpp;
      ch = p / 10;
      b  = p % 10;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return w[ch*8 + b - 1];
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int CPP   = (gi == 0) ? 4 : 1;
      localparam int TOTAL = 20 * CPP;

      uart_tx #(
         .CLOCKS_PER_PULSE(CPP),
         .BITS_PER_WORD   (8),
         .W_in            (16)
      ) dut (
         .clk    (clk),
         .rst    (rst[gi]),
         .s_valid(s_valid[gi]),
         .s_ready(s_ready[gi]),
         .s_data (s_data[gi]),
         .tx     (tx[gi]),
         .busy   (busy[gi])
      );

      logic        armed   = 1'b0;
      logic        exp_tx  = 1'b1;
      logic        exp_bsy = 1'b0;
      logic        exp_rdy = 1'b0;
      int          k       = -1;
      logic [15:0] word    = '0;
      logic [15:0] sb[$];
      logic        rx_act  = 1'b0;
      int          rx_off  = 0;
      int          nch     = 0;
      logic [7:0]  rx_ch   = '0;
      logic [15:0] rx_word = '0;

      initial forever begin
         @(negedge clk);
         if (armed) begin
            check("tx", gi, tx[gi], exp_tx);
            check("busy", gi, busy[gi], exp_bsy);
            check("s_ready", gi, s_ready[gi], exp_rdy);
         end
         // Serial receiver: mid-bit sampling of the line.
         if (!rst[gi]) begin
            if (!rx_act) begin
               if (tx[gi] === 1'b0) begin
                  rx_act = 1'b1;
                  rx_off = 0;
               end
            end else begin
               rx_off++;
            end
            if (rx_act && (rx_off % CPP == CPP / 2)) begin
               int b;
               b = rx_off / CPP;
               if (b >= 1 && b <= 8) begin
                  rx_ch[b-1] = tx[gi];
               end else if (b == 9) begin
                  check("stop_bit", gi, tx[gi], 1);
                  rx_word[nch*8 +: 8] = rx_ch;
                  nch++;
                  rx_act = 1'b0;
                  if (nch == 2) begin
                     nch = 0;
                     n_rx[gi]++;
                     if (sb.size() == 0) check("rx_unexpected_word", gi, rx_word, 32'hFFFF_FFFF);
                     else check("rx_word", gi, rx_word, sb.pop_front());
                  end
               end
            end
         end
         // Model step: expected outputs after the coming posedge.
         if (rst[gi]) begin
            armed   = 1'b1;
            exp_tx  = 1'b1;
            exp_bsy = 1'b0;
            exp_rdy = 1'b0;
            k       = -1;
            sb.delete();
            rx_act  = 1'b0;
            nch     = 0;
         end else if (armed) begin
            if (k < 0) begin
               if (s_valid[gi] && exp_rdy) begin
                  word = s_data[gi];
                  sb.push_back(word);
                  k       = 0;
                  exp_tx  = fbit(word, 0, CPP);
                  exp_bsy = 1'b1;
                  exp_rdy = 1'b0;
               end else begin
                  exp_tx  = 1'b1;
                  exp_bsy = 1'b0;
                  exp_rdy = 1'b1;
               end
            end else begin
               k++;
               if (k == TOTAL) begin
                  k       = -1;
                  exp_tx  = 1'b1;
                  exp_bsy = 1'b0;
                  exp_rdy = 1'b1;
               end else begin
                  exp_tx = fbit(word, k, CPP);
               end
            end
         end
      end
   end

   task automatic send(input int i, input logic [15:0] w, input int gap, output int hs_cyc);
      int t;
      s_valid[i] = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      s_valid[i] = 1'b1;
      s_data[i]  = w;
      hs_cyc     = -1;
      t          = 0;
      while (t < 1000) begin
         @(negedge clk);
         if (s_ready[i] === 1'b1) begin
            hs_cyc = cyc;
            break;
         end
         t++;
      end
      if (hs_cyc < 0) check("handshake_timeout", i, 0, 1);
      @(posedge clk);
      #1;
      s_valid[i] = 1'b0;
      s_data[i]  = 16'($urandom);
      n_req[i]++;
   endtask

   task automatic wait_idle(input int i);
      int t;
      t = 0;
      while (t < 2000) begin
         @(negedge clk);
         if (busy[i] === 1'b0 && s_ready[i] === 1'b1) break;
         t++;
      end
      if (t >= 2000) check("idle_timeout", i, 0, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, required completion within 1 ms");
      $fatal(1, "tb_uart_tx watchdog expired");
   end

   initial begin
      logic [19:0] pat;
      int          h, h1, h2, h3, err, cnt;

      for (int i = 0; i < 2; i++) begin
         rst[i]     = 1'b1;
         s_valid[i] = 1'b0;
         s_data[i]  = '0;
      end

      // Reset values, then s_ready rises once reset is released.
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("rst_tx", i, tx[i], 1);
         check("rst_s_ready", i, s_ready[i], 0);
         check("rst_busy", i, busy[i], 0);
      end
      @(posedge clk);
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("ready_after_rst", 0, s_ready[0], 1);
      check("ready_after_rst", 1, s_ready[1], 1);
      @(posedge clk);
      #1;

      // Pin the frame model to the hand-derived waveform of 16'hA53C.
      pat = 20'b11010010101001111000;
      err = 0;
      for (int j = 0; j < 80; j++) if (fbit(16'hA53C, j, 4) !== pat[j/4]) err++;
      for (int j = 0; j < 20; j++) if (fbit(16'hA53C, j, 1) !== pat[j]) err++;
      check("model_pin", 0, err, 0);

      // Single word: literal waveform and busy length.
      send(0, 16'hA53C, 0, h);
      err = 0;
      cnt = 0;
      for (int j = 0; j < 80; j++) begin
         @(negedge clk);
         if (tx[0] !== pat[j/4]) err++;
         if (busy[0] === 1'b1) cnt++;
      end
      check("a53c_wave", 0, err, 0);
      check("a53c_busy_cycles", 0, cnt, 80);
      @(negedge clk);
      check("a53c_end_tx", 0, tx[0], 1);
      check("a53c_end_busy", 0, busy[0], 0);
      @(posedge clk);
      #1;

      // Back-to-back: one idle cycle between frames.
      send(0, 16'h0000, 0, h1);
      send(0, 16'hFFFF, 0, h2);
      send(0, 16'h8001, 0, h3);
      check("b2b_gap_1", 0, h2 - h1, 81);
      check("b2b_gap_2", 0, h3 - h2, 81);
      wait_idle(0);

      // Reset during bit 5 of character 0.
      send(0, 16'hC3A5, 0, h);
      repeat (21) @(posedge clk);
      #1;
      rst[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_tx", 0, tx[0], 1);
      check("abort_busy", 0, busy[0], 0);
      check("abort_s_ready", 0, s_ready[0], 0);
      @(posedge clk);
      #1;
      rst[0] = 1'b0;
      n_abort[0]++;
      send(0, 16'h1234, 0, h);
      wait_idle(0);

      // Stall: idle line with no handshake.
      cnt = 0;
      for (int j = 0; j < 50; j++) begin
         @(negedge clk);
         if (tx[0] === 1'b1 && busy[0] === 1'b0 && s_ready[0] === 1'b1) cnt++;
      end
      check("stall_idle_cycles", 0, cnt, 50);
      @(posedge clk);
      #1;

      // Input data churn while busy must not affect the frame.
      send(0, 16'h5AF0, 0, h);
      repeat (40) begin
         s_data[0] = 16'($urandom);
         @(posedge clk);
         #1;
      end
      wait_idle(0);

      // Random words with random gaps on both instances.
      fork
         begin
            int hh;
            for (int j = 0; j < 100; j++) send(0, 16'($urandom), $urandom_range(0, 20), hh);
            wait_idle(0);
         end
         begin
            int hh;
            for (int j = 0; j < 100; j++) send(1, 16'($urandom), $urandom_range(0, 20), hh);
            wait_idle(1);
         end
      join

      repeat (5) @(posedge clk);
      #1;
      check("rx_count", 0, n_rx[0], n_req[0] - n_abort[0]);
      check("rx_count", 1, n_rx[1], n_req[1] - n_abort[1]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
